// File: rtl/hotswap_monitor_core.sv
// Hotswap monitor: per-channel ON-pin debounce, triggered V/I conversion capture,
// threshold alerts and a small byte-wide register file selected by ch_i.

package hotswap_monitor_pkg;
  // Register access request routed to one channel
  typedef struct packed {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] dat;
  } reg_req_t;

  localparam logic [2:0] A_CMD = 3'd0;
  localparam logic [2:0] A_EN  = 3'd1;
  localparam logic [2:0] A_TH  = 3'd2;
  localparam logic [2:0] A_CTL = 3'd3;
  localparam logic [2:0] A_VHI = 3'd4;
  localparam logic [2:0] A_VLO = 3'd5;
  localparam logic [2:0] A_IHI = 3'd6;
  localparam logic [2:0] A_ILO = 3'd7;
endpackage

// One monitored channel: ON filter, conversion FSM, result/alert registers.
module hotswap_monitor_ch
  import hotswap_monitor_pkg::*;
#(
  parameter int FILTER_CYCLES = 3000,
  parameter int CONV_CYCLES   = 1500
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        on_raw_i,
  input  logic [11:0] adc_v_i,
  input  logic [11:0] adc_i_i,
  input  reg_req_t    req,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  output logic        on_state_o,
  output logic        alert_any_o
);
  localparam int FW = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
  localparam int CW = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;

  typedef enum logic { S_IDLE = 1'b0, S_CONV = 1'b1 } st_t;

  st_t            st_q, st_d;
  logic [1:0]     sync_q;
  logic           on_q;
  logic [FW-1:0]  fcnt_q;
  logic [CW-1:0]  ccnt_q;
  logic           req_v_q, req_i_q, range_q, sw_off_q;
  logic [4:0]     en_q;
  logic [7:0]     th_q;
  logic [11:0]    v_q, i_q;
  logic           av_q, ai_q, aon_q;

  logic cmd_wr, start, done, on_tgl, clr;
  logic set_v, set_i, set_on;

  // Command writes only act in IDLE; a conversion needs at least one of bit1/bit3
  assign cmd_wr = req.wr && (req.addr == A_CMD);
  assign start  = cmd_wr && (st_q == S_IDLE) && (req.dat[1] || req.dat[3]);
  assign done   = (st_q == S_CONV) && (ccnt_q == '0);
  assign clr    = req.wr && (req.addr == A_CTL) && req.dat[1];
  // Filter fires on the FILTER_CYCLES-th consecutive disagreeing cycle
  assign on_tgl = (sync_q[1] != on_q) && (fcnt_q == FW'(FILTER_CYCLES - 1));

  // Alerts compare the value being captured this edge, not the stale result
  assign set_v  = done && req_v_q && en_q[1] && (adc_v_i[11:4] > th_q);
  assign set_i  = done && req_i_q && en_q[2] && (adc_i_i[11:4] > th_q);
  assign set_on = on_tgl && en_q[0];

  // Synchroniser and persistence filter for the raw ON pin
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b00;
      on_q   <= 1'b0;
      fcnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], on_raw_i};
      if (sync_q[1] == on_q) begin
        fcnt_q <= '0;
      end else if (on_tgl) begin
        on_q   <= sync_q[1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  // Conversion FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) st_q <= S_IDLE;
    else          st_q <= st_d;
  end

  // Conversion FSM next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  if (start) st_d = S_CONV;
      S_CONV:  if (done)  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // Conversion FSM outputs
  always_comb begin
    busy_o = (st_q == S_CONV);
  end

  // Conversion countdown, request latching and result capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ccnt_q  <= '0;
      req_v_q <= 1'b0;
      req_i_q <= 1'b0;
      range_q <= 1'b0;
      v_q     <= 12'h000;
      i_q     <= 12'h000;
    end else begin
      if (cmd_wr && (st_q == S_IDLE)) range_q <= req.dat[4];
      if (start) begin
        // Loaded with N-1 so capture lands N edges after the write edge
        ccnt_q  <= CW'(CONV_CYCLES - 1);
        req_v_q <= req.dat[1];
        req_i_q <= req.dat[3];
      end else if ((st_q == S_CONV) && !done) begin
        ccnt_q <= ccnt_q - CW'(1);
      end
      if (done && req_v_q) v_q <= adc_v_i;
      if (done && req_i_q) i_q <= adc_i_i;
    end
  end

  // Configuration registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q     <= 5'b00100;
      th_q     <= 8'hFF;
      sw_off_q <= 1'b0;
    end else if (req.wr) begin
      case (req.addr)
        A_EN:    en_q     <= req.dat[4:0];
        A_TH:    th_q     <= req.dat;
        A_CTL:   sw_off_q <= req.dat[0];
        default: ;
      endcase
    end
  end

  // Sticky alerts: a set in the same cycle as a clear wins
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      av_q  <= 1'b0;
      ai_q  <= 1'b0;
      aon_q <= 1'b0;
    end else begin
      av_q  <= set_v  | (av_q  & ~clr);
      ai_q  <= set_i  | (ai_q  & ~clr);
      aon_q <= set_on | (aon_q & ~clr);
    end
  end

  // Read data mux for this channel
  always_comb begin
    rdata_o = 8'h00;
    case (req.addr)
      A_CMD:   rdata_o = {2'b00, on_q, (~on_q | sw_off_q), aon_q, ai_q, av_q, (st_q == S_CONV)};
      A_EN:    rdata_o = {3'b000, en_q};
      A_TH:    rdata_o = th_q;
      A_CTL:   rdata_o = {7'b0, sw_off_q};
      A_VHI:   rdata_o = v_q[11:4];
      A_VLO:   rdata_o = {v_q[3:0], 4'h0};
      A_IHI:   rdata_o = i_q[11:4];
      A_ILO:   rdata_o = {i_q[3:0], 4'h0};
      default: rdata_o = 8'h00;
    endcase
  end

  assign on_state_o  = on_q;
  assign alert_any_o = av_q | ai_q | aon_q;
endmodule

// Top: NCH channel instances, channel-selected register port, global alert.
module hotswap_monitor_core
  import hotswap_monitor_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int FILTER_CYCLES = 3000,
  parameter int CONV_CYCLES   = 1500
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NCH-1:0]    on_i,
  input  logic [12*NCH-1:0] adc_v_i,
  input  logic [12*NCH-1:0] adc_i_i,
  input  logic [2:0]        ch_i,
  input  logic [2:0]        addr_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [7:0]        dat_i,
  output logic [7:0]        dat_o,
  output logic [NCH-1:0]    busy_o,
  output logic [NCH-1:0]    on_state_o,
  output logic              alert_o
);
  logic [NCH-1:0][7:0] ch_rdata;
  logic [NCH-1:0]      ch_alert;
  logic [7:0][7:0]     rd_all;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    reg_req_t req;
    // Only the selected channel sees the write strobe; unpopulated ch_i hits none
    assign req = '{wr: wr_i && (ch_i == 3'(k)), addr: addr_i, dat: dat_i};

    hotswap_monitor_ch #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .CONV_CYCLES   (CONV_CYCLES)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .on_raw_i    (on_i[k]),
      .adc_v_i     (adc_v_i[12*k +: 12]),
      .adc_i_i     (adc_i_i[12*k +: 12]),
      .req         (req),
      .rdata_o     (ch_rdata[k]),
      .busy_o      (busy_o[k]),
      .on_state_o  (on_state_o[k]),
      .alert_any_o (ch_alert[k])
    );
  end

  // Pad to all 8 ch_i codes so unpopulated channels read as zero
  always_comb begin
    rd_all = '0;
    for (int k = 0; k < NCH; k++) rd_all[k] = ch_rdata[k];
  end

  // Registered read port; value captured before any same-cycle write lands
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  dat_o <= 8'h00;
    else if (rd_i) dat_o <= rd_all[ch_i];
  end

  // Global alert, one cycle behind the sticky bits
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) alert_o <= 1'b0;
    else          alert_o <= |ch_alert;
  end
endmodule
